lmhead_argmax_sched: RTL

Sequencer for the final LM-head stage: HBM MVM + BN + residual + argmax.
- Splits the output-channel dimension into Tout-wide tiles and issues one MVM job per tile, with that tile's HBM weight address.
- Consumes the per-token Tout-lane FP16 result vectors, reduces them, and keeps a running max and index per token.
- After the last tile, streams one argmax index per token to the write-back logic.

It sits between the host register file and the MVM/BN/Res datapath.

---
 rtl/lmhead_argmax_sched.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lmhead_argmax_sched.sv
// LM-head argmax sequencer: issues one MVM job per Tout-wide channel tile, folds
// each token's result beats into a running max/index, then streams one argmax per token.
module lmhead_argmax_sched #(
  parameter int TOUT      = 32,
  parameter int DAT_DW    = 16,
  parameter int MAX_TOKEN = 128,
  parameter int IDX_W     = 32,
  localparam int CT_W     = $clog2(MAX_TOKEN + 1),
  localparam int OT_W     = $clog2(MAX_TOKEN)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [CT_W-1:0]        cfg_token_i,
  input  logic [IDX_W-1:0]       cfg_chout_i,
  input  logic [IDX_W-1:0]       cfg_tiles_i,
  input  logic [31:0]            cfg_wt_base_i,
  input  logic [31:0]            cfg_wt_tile_stride_i,
  output logic                   mvm_start_o,
  output logic [31:0]            mvm_wt_addr_o,
  output logic [IDX_W-1:0]       mvm_tile_o,
  input  logic                   mvm_done_i,
  input  logic                   res_valid_i,
  output logic                   res_ready_o,
  input  logic [TOUT*DAT_DW-1:0] res_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [OT_W-1:0]        out_token_o,
  output logic [IDX_W-1:0]       out_index_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Map FP16 onto an unsigned-comparable key: negatives reversed, positives above them.
  function automatic logic [DAT_DW-1:0] fp_key(input logic [DAT_DW-1:0] x);
    logic [DAT_DW-1:0] k;
    if (x[DAT_DW-1]) begin
      k = ~x;
    end else begin
      k = x ^ {1'b1, {(DAT_DW-1){1'b0}}};
    end
    return k;
  endfunction

  state_e             state_q;
  logic [CT_W-1:0]    cfg_token_q;
  logic [IDX_W-1:0]   cfg_chout_q;
  logic [IDX_W-1:0]   cfg_tiles_q;
  logic [31:0]        cfg_stride_q;
  logic [IDX_W-1:0]   tile_q;
  logic [IDX_W-1:0]   chan_base_q;
  logic [31:0]        wt_addr_q;
  logic [CT_W-1:0]    beat_cnt_q;
  logic               done_seen_q;
  logic               mvm_start_q;
  logic               res_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               done_q;
  logic [OT_W-1:0]    out_token_q;
  logic [IDX_W-1:0]   out_index_q;

  logic               s1_vld_q;
  logic               s1_first_q;
  logic               s1_any_q;
  logic [DAT_DW-1:0]  s1_key_q;
  logic [IDX_W-1:0]   s1_ch_q;
  logic [OT_W-1:0]    s1_tok_q;
  logic               s1_any_d;
  logic [DAT_DW-1:0]  s1_key_d;
  logic [IDX_W-1:0]   s1_ch_d;

  logic [DAT_DW-1:0]  best_key_q [MAX_TOKEN];
  logic [IDX_W-1:0]   best_ch_q  [MAX_TOKEN];
  logic               best_vld_q [MAX_TOKEN];

  logic               res_fire;
  logic               leave_wait;
  logic               more_tiles;
  logic               out_fire;
  logic               last_token;
  logic               wr_en;
  logic [DAT_DW-1:0]  rd_key;
  logic               rd_vld;
  logic [OT_W-1:0]    nxt_tok;
  logic [IDX_W-1:0]   nxt_idx;

  assign res_fire   = res_valid_i & res_ready_q;
  assign leave_wait = (state_q == S_WAIT) & done_seen_q & (beat_cnt_q == cfg_token_q);
  assign more_tiles = (tile_q + IDX_W'(1)) < cfg_tiles_q;
  assign out_fire   = out_valid_q & out_ready_i;
  assign last_token = ({1'b0, out_token_q} == (cfg_token_q - CT_W'(1)));

  // Stage-1 reduction: best unmasked lane of the incoming beat, lowest channel on ties.
  always_comb begin
    s1_any_d = 1'b0;
    s1_key_d = '0;
    s1_ch_d  = '0;
    for (int k = 0; k < TOUT; k++) begin
      if (((chan_base_q + IDX_W'(k)) < cfg_chout_q) &&
          (!s1_any_d || (fp_key(res_data_i[k*DAT_DW +: DAT_DW]) > s1_key_d))) begin
        s1_any_d = 1'b1;
        s1_key_d = fp_key(res_data_i[k*DAT_DW +: DAT_DW]);
        s1_ch_d  = chan_base_q + IDX_W'(k);
      end else begin
        s1_any_d = s1_any_d;
        s1_key_d = s1_key_d;
        s1_ch_d  = s1_ch_d;
      end
    end
  end

  // Stage-1 register holding the reduced candidate and its token.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_any_q   <= 1'b0;
      s1_key_q   <= '0;
      s1_ch_q    <= '0;
      s1_tok_q   <= '0;
    end else begin
      s1_vld_q <= res_fire;
      if (res_fire) begin
        s1_first_q <= (tile_q == '0);
        s1_any_q   <= s1_any_d;
        s1_key_q   <= s1_key_d;
        s1_ch_q    <= s1_ch_d;
        s1_tok_q   <= beat_cnt_q[OT_W-1:0];
      end
    end
  end

  // Stage-2 compare against the stored best; the flop store makes back-to-back
  // same-token updates visible on the very next read.
  always_comb begin
    rd_key = best_key_q[s1_tok_q];
    rd_vld = best_vld_q[s1_tok_q];
    if (s1_vld_q) begin
      wr_en = s1_first_q | (s1_any_q & (~rd_vld | (s1_key_q > rd_key)));
    end else begin
      wr_en = 1'b0;
    end
  end

  // Running max store; tile 0 rewrites every entry, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      best_key_q[s1_tok_q] <= s1_key_q;
      best_ch_q[s1_tok_q]  <= s1_any_q ? s1_ch_q : '0;
      best_vld_q[s1_tok_q] <= s1_any_q;
    end
  end

  // Index presented next on the output stream; tokens without a valid lane report 0.
  always_comb begin
    if (state_q == S_OUT) begin
      nxt_tok = out_token_q + OT_W'(1);
    end else begin
      nxt_tok = '0;
    end
    if (best_vld_q[nxt_tok]) begin
      nxt_idx = best_ch_q[nxt_tok];
    end else begin
      nxt_idx = '0;
    end
  end

  // Job sequencer with registered control outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cfg_token_q  <= '0;
      cfg_chout_q  <= '0;
      cfg_tiles_q  <= '0;
      cfg_stride_q <= '0;
      tile_q       <= '0;
      chan_base_q  <= '0;
      wt_addr_q    <= '0;
      beat_cnt_q   <= '0;
      done_seen_q  <= 1'b0;
      mvm_start_q  <= 1'b0;
      res_ready_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_token_q  <= '0;
      out_index_q  <= '0;
    end else begin
      mvm_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cfg_token_q  <= cfg_token_i;
            cfg_chout_q  <= cfg_chout_i;
            cfg_tiles_q  <= cfg_tiles_i;
            cfg_stride_q <= cfg_wt_tile_stride_i;
            tile_q       <= '0;
            chan_base_q  <= '0;
            wt_addr_q    <= cfg_wt_base_i;
            beat_cnt_q   <= '0;
            done_seen_q  <= 1'b0;
            mvm_start_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mvm_done_i) begin
            done_seen_q <= 1'b1;
          end
          res_ready_q <= (cfg_token_q != '0);
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (res_fire) begin
            beat_cnt_q <= beat_cnt_q + CT_W'(1);
            if ((beat_cnt_q + CT_W'(1)) == cfg_token_q) begin
              res_ready_q <= 1'b0;
            end
          end
          if (leave_wait) begin
            done_seen_q <= 1'b0;
            beat_cnt_q  <= '0;
            res_ready_q <= 1'b0;
            if (more_tiles) begin
              tile_q      <= tile_q + IDX_W'(1);
              chan_base_q <= chan_base_q + IDX_W'(TOUT);
              wt_addr_q   <= wt_addr_q + cfg_stride_q;
              mvm_start_q <= 1'b1;
              state_q     <= S_ISSUE;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (mvm_done_i) begin
            done_seen_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!s1_vld_q) begin
            out_valid_q <= 1'b1;
            out_token_q <= '0;
            out_index_q <= nxt_idx;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_fire) begin
            if (last_token) begin
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              out_token_q <= nxt_tok;
              out_index_q <= nxt_idx;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mvm_start_o   = mvm_start_q;
  assign mvm_wt_addr_o = wt_addr_q;
  assign mvm_tile_o    = tile_q;
  assign res_ready_o   = res_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_token_o   = out_token_q;
  assign out_index_o   = out_index_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
